// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (double dabble) for 7-segment digit decoders.
// Optional build macro LEADING_ZERO_BLANK_EN blanks zero digits above the leading digit.
module bin_to_bcd_seq #(
    parameter int W      = 14,
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [W-1:0]          bin_in,
    output logic                  busy,
    output logic                  done,
    output logic                  ovf,
    output logic [DIGITS*4-1:0]   bcd_digits
);

    localparam int          SW   = DIGITS * 4;
    localparam int          CW   = $clog2(W + 1);
    localparam int unsigned MAXV = 10 ** DIGITS - 1;
    localparam logic [CW-1:0] LAST = CW'(W - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t          r_state;
    logic [W-1:0]    r_shf;
    logic [SW-1:0]   r_scr;
    logic [CW-1:0]   r_cnt;
    logic            r_ovf_pend;
    logic            r_busy;
    logic            r_done;
    logic            r_ovf;
    logic [SW-1:0]   r_bcd;

    logic [SW-1:0]   w_adj;
    logic [SW-1:0]   w_res;
    logic            w_ovf_in;

    assign w_ovf_in = 32'(bin_in) > MAXV;

    // add-3 wraps within the nibble; only matters once the value has overflowed
    always_comb begin
        w_adj = r_scr;
        for (int i = 0; i < DIGITS; i++) begin
            if (r_scr[i*4 +: 4] >= 4'd5)
                w_adj[i*4 +: 4] = r_scr[i*4 +: 4] + 4'd3;
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    always_comb begin
        logic w_seen;
        w_res  = r_scr;
        w_seen = 1'b0;
        for (int i = DIGITS - 1; i > 0; i--) begin
            if (r_scr[i*4 +: 4] != 4'd0)
                w_seen = 1'b1;
            else if (!w_seen)
                w_res[i*4 +: 4] = 4'hF;
        end
    end
`else
    assign w_res = r_scr;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_shf      <= '0;
            r_scr      <= '0;
            r_cnt      <= '0;
            r_ovf_pend <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_ovf      <= 1'b0;
            r_bcd      <= '1;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_shf      <= bin_in;
                        r_scr      <= '0;
                        r_cnt      <= '0;
                        r_ovf_pend <= w_ovf_in;
                        r_busy     <= 1'b1;
                        r_state    <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    r_scr <= {w_adj[SW-2:0], r_shf[W-1]};
                    r_shf <= r_shf << 1;
                    r_cnt <= r_cnt + CW'(1);
                    if (r_cnt == LAST)
                        r_state <= S_DONE;
                end
                S_DONE: begin
                    r_bcd   <= r_ovf_pend ? '1 : w_res;
                    r_ovf   <= r_ovf_pend;
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy       = r_busy;
    assign done       = r_done;
    assign ovf        = r_ovf;
    assign bcd_digits = r_bcd;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Scoreboard bench for bin_to_bcd_seq: directed vectors plus a stepped sweep.
// Honours LEADING_ZERO_BLANK_EN for the expected digit patterns.
module tb_bin_to_bcd_seq;

    localparam int W      = 14;
    localparam int DIGITS = 4;

`ifdef LEADING_ZERO_BLANK_EN
    localparam logic [16:0] E0  = 17'h0FFF0;
    localparam logic [16:0] E42 = 17'h0FF42;
    localparam logic [16:0] E5  = 17'h0FFF5;
`else
    localparam logic [16:0] E0  = 17'h00000;
    localparam logic [16:0] E42 = 17'h00042;
    localparam logic [16:0] E5  = 17'h00005;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [W-1:0] bin_in = '0;
    logic        busy;
    logic        done;
    logic        ovf;
    logic [15:0] bcd_digits;

    int total = 0;
    int bad = 0;
    int n_done = 0;
    logic [16:0] sb_q[$];
    logic [16:0] m_exp;

    always #5 clk = ~clk;

    bin_to_bcd_seq #(.W(W), .DIGITS(DIGITS)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .bin_in     (bin_in),
        .busy       (busy),
        .done       (done),
        .ovf        (ovf),
        .bcd_digits (bcd_digits)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h required %0h", nm, act, exp);
        end
    endtask

    // decimal reference: digit i is blank (optionally) when v < 10^i
    function automatic logic [16:0] model(input int v);
        logic [15:0] d;
        int t;
        int pw;
        if (v > 9999) return 17'h1FFFF;
        t = v;
        for (int i = 0; i < 4; i++) begin
            d[i*4 +: 4] = 4'(t % 10);
            t = t / 10;
        end
`ifdef LEADING_ZERO_BLANK_EN
        pw = 10;
        for (int i = 1; i < 4; i++) begin
            if (v < pw) d[i*4 +: 4] = 4'hF;
            pw = pw * 10;
        end
`else
        pw = 0;
`endif
        return {1'b0, d};
    endfunction

    always @(negedge clk) begin
        if (rst_n && done) begin
            n_done++;
            if (sb_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: got done=1 required no pending conversion");
            end else begin
                m_exp = sb_q.pop_front();
                chk("result", {15'd0, ovf, bcd_digits}, {15'd0, m_exp});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input int v, input logic [16:0] exp, input bit push);
        int n;
        n = 0;
        while (busy && n < 100) begin
            tick();
            n++;
        end
        chk("idle_timeout", {31'd0, busy}, 32'd0);
        start  = 1'b1;
        bin_in = W'(v);
        if (push) sb_q.push_back(exp);
        tick();
        start  = 1'b0;
        bin_in = 14'h3FFF;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 200) begin
            tick();
            n++;
        end
        chk("drain", sb_q.size(), 0);
    endtask

    int          dv[7] = '{1234, 9999, 0, 42, 10000, 5, 16383};
    logic [16:0] de[7] = '{17'h01234, 17'h09999, E0, E42, 17'h1FFFF, E5, 17'h1FFFF};

    initial begin
        int k;
        int d0;
        repeat (3) tick();
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("reset_state", {13'd0, busy, done, ovf, bcd_digits}, {13'd0, 3'b000, 16'hFFFF});
        end

        issue(1234, 17'h01234, 1);
        chk("busy_on_accept", {31'd0, busy}, 32'd1);
        k = 0;
        while (!done && k < 40) begin
            tick();
            k++;
        end
        chk("latency", k, 15);
        chk("busy_at_done", {31'd0, busy}, 32'd0);
        tick();
        chk("done_width", {31'd0, done}, 32'd0);
        repeat (5) tick();
        chk("hold", {16'd0, bcd_digits}, 32'h1234);

        for (int i = 0; i < 7; i++) issue(dv[i], de[i], 1);
        drain();

        d0 = n_done;
        issue(1234, 17'h01234, 1);
        repeat (2) tick();
        start = 1'b1; bin_in = 14'd77;
        tick();
        start = 1'b0;
        repeat (10) tick();
        start = 1'b1; bin_in = 14'd9;
        repeat (2) tick();
        start = 1'b0;
        chk("done_edge15", {31'd0, done}, 32'd1);
        repeat (20) tick();
        chk("single_done", n_done - d0, 1);
        chk("busy_ignored", {31'd0, busy}, 32'd0);

        d0 = n_done;
        issue(4321, 17'h04321, 0);
        repeat (7) tick();
        rst_n = 1'b0;
        #1;
        chk("abort_reset", {13'd0, busy, done, ovf, bcd_digits}, {13'd0, 3'b000, 16'hFFFF});
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (25) tick();
        chk("no_done_after_reset", n_done - d0, 0);
        issue(5678, 17'h05678, 1);
        drain();

        k = 0;
        while (busy && k < 100) begin
            tick();
            k++;
        end
        start = 1'b1; bin_in = 14'd321;
        sb_q.push_back(model(321));
        sb_q.push_back(model(321));
        repeat (17) tick();
        chk("retrigger_busy", {31'd0, busy}, 32'd1);
        start = 1'b0;
        drain();

        for (int v = 0; v < 10000; v += 7) issue(v, model(v), 1);
        issue(9999, model(9999), 1);
        issue(10, model(10), 1);
        issue(100, model(100), 1);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: got no end of test required finish");
        $fatal(1);
    end

endmodule
